// File: rtl/instruction_fetch_queue_pkg.sv
// Shared fetch-path definitions: default bus widths, the fetch entry handed to
// decode, and sizing helpers for the queue counters and pointers.
package instruction_fetch_queue_pkg;

   localparam int IFQ_DIR_SIZE  = 32;
   localparam int IFQ_DATA_SIZE = 32;

   typedef struct packed {
      logic [IFQ_DIR_SIZE-1:0]  dir;
      logic [IFQ_DATA_SIZE-1:0] instr;
   } fetch_entry_t;

   // Occupancy must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue bus: PC credit, instruction-memory read port and the decode
// handshake. master = fetch queue, slave = PC/memory/decode side.
interface instruction_fetch_queue_if #(
   parameter int DIR_SIZE  = instruction_fetch_queue_pkg::IFQ_DIR_SIZE,
   parameter int DATA_SIZE = instruction_fetch_queue_pkg::IFQ_DATA_SIZE,
   parameter int DEPTH     = 4
);
   import instruction_fetch_queue_pkg::*;

   localparam int CNT_W = cnt_width(DEPTH);

   logic [DIR_SIZE-1:0]  pc_dir;
   logic                 pc_enable;
   logic                 flush;
   logic [DIR_SIZE-1:0]  mem_addr;
   logic                 mem_rd;
   logic [DATA_SIZE-1:0] mem_data;
   logic [DATA_SIZE-1:0] instr_out;
   logic [DIR_SIZE-1:0]  instr_dir;
   logic                 instr_valid;
   logic                 instr_ready;
   logic [CNT_W-1:0]     count;

   modport master (
      input  pc_dir, flush, mem_data, instr_ready,
      output pc_enable, mem_addr, mem_rd, instr_out, instr_dir, instr_valid, count
   );

   modport slave (
      output pc_dir, flush, mem_data, instr_ready,
      input  pc_enable, mem_addr, mem_rd, instr_out, instr_dir, instr_valid, count
   );

endinterface

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// DEPTH-entry synchronous FIFO with clear; read data is combinational from the
// head slot and forced to zero while empty.
module instruction_fetch_queue_fetch_fifo #(
   parameter int  WIDTH = 64,
   parameter int  DEPTH = 4,
   localparam int CNT_W = instruction_fetch_queue_pkg::cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   import instruction_fetch_queue_pkg::*;

   localparam int PTR_W = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the output mux hides it until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues reads from the PC address under a credit
// limit, tracks them through the memory latency and buffers returns for decode.
module instruction_fetch_queue #(
   parameter int DIR_SIZE    = instruction_fetch_queue_pkg::IFQ_DIR_SIZE,
   parameter int DATA_SIZE   = instruction_fetch_queue_pkg::IFQ_DATA_SIZE,
   parameter int MEM_LATENCY = 2,
   parameter int DEPTH       = 4
) (
   input logic                      clk,
   input logic                      rst,
   instruction_fetch_queue_if.master bus
);
   import instruction_fetch_queue_pkg::*;

   localparam int CNT_W = cnt_width(DEPTH);
   localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

   logic                vld_q  [MEM_LATENCY];
   logic                vld_d  [MEM_LATENCY];
   logic [DIR_SIZE-1:0] addr_q [MEM_LATENCY];
   logic [DIR_SIZE-1:0] addr_d [MEM_LATENCY];

   logic [CNT_W-1:0]              inflight;
   logic [CNT_W:0]                credit_sum;
   logic                          issue;
   logic [CNT_W-1:0]              fifo_count;
   logic                          fifo_full, fifo_empty;
   logic                          push, pop;
   logic [DIR_SIZE+DATA_SIZE-1:0] push_data, pop_data;

   // Latency pipe: one valid/address pair per outstanding read; a flush kills all.
   for (genvar gi = 0; gi < MEM_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
         assign vld_d[gi]  = issue && !bus.flush;
         assign addr_d[gi] = bus.pc_dir;
      end else begin : g_tail
         assign vld_d[gi]  = vld_q[gi-1] && !bus.flush;
         assign addr_d[gi] = addr_q[gi-1];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_q[gi]  <= 1'b0;
            addr_q[gi] <= '0;
         end else begin
            vld_q[gi]  <= vld_d[gi];
            addr_q[gi] <= addr_d[gi];
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + CNT_W'(vld_q[i]);
      end
   end

   // Buffered plus outstanding reads may never exceed the FIFO depth.
   assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
   assign issue      = rst && !bus.flush && (credit_sum < CREDIT_LIMIT);

   assign bus.pc_enable = issue;
   assign bus.mem_rd    = issue;
   assign bus.mem_addr  = bus.pc_dir;

   // Entry layout matches fetch_entry_t: {dir, instr}.
   assign push      = vld_q[MEM_LATENCY-1];
   assign push_data = {addr_q[MEM_LATENCY-1], bus.mem_data};
   assign pop       = bus.instr_valid && bus.instr_ready && !bus.flush;

   instruction_fetch_queue_fetch_fifo #(
      .WIDTH (DIR_SIZE + DATA_SIZE),
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (bus.flush),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign {bus.instr_dir, bus.instr_out} = pop_data;
   assign bus.instr_valid = !fifo_empty;
   assign bus.count       = fifo_count;

   a_no_push_when_full: assert property (
      @(posedge clk) disable iff (!rst) !(push && fifo_full && !bus.flush)
   );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: vector table for credit and
// occupancy, scoreboard for delivered order, hand sequences for flush/reset.
module tb_instruction_fetch_queue;
   import instruction_fetch_queue_pkg::*;

   localparam int L = 2;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instruction_fetch_queue_if #(.DIR_SIZE(32), .DATA_SIZE(32), .DEPTH(D)) ifc ();

   instruction_fetch_queue #(
      .DIR_SIZE(32), .DATA_SIZE(32), .MEM_LATENCY(L), .DEPTH(D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // Instruction memory: word = addr + 0x1000, L cycles after the request.
   logic [31:0] mpipe [L];
   always @(posedge clk) begin
      mpipe[0] <= ifc.mem_addr;
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
   end
   assign ifc.mem_data = mpipe[L-1] + 32'h1000;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_pop  = 0;
   logic [31:0] target;
   fetch_entry_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: issues push expectations, pops compare, flush/reset discard.
   always @(negedge clk) begin
      fetch_entry_t e;
      if (!rst) begin
         exp_q.delete();
      end else if (ifc.flush) begin
         check("flush_no_issue", 32'(ifc.pc_enable), 32'd0);
         exp_q.delete();
      end else begin
         if (ifc.instr_valid && ifc.instr_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               check("pop_unexpected", ifc.instr_dir, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("pop_dir", ifc.instr_dir, e.dir);
               check("pop_instr", ifc.instr_out, e.instr);
               $display("pop dir=0x%0h instr=0x%0h", ifc.instr_dir, ifc.instr_out);
            end
         end
         if (ifc.pc_enable) begin
            check("issue_addr", ifc.mem_addr, ifc.pc_dir);
            e.dir   = ifc.pc_dir;
            e.instr = ifc.pc_dir + 32'h1000;
            exp_q.push_back(e);
         end
      end
   end

   // One clock: PC advances on pc_enable, or redirects on flush.
   task automatic cyc();
      bit en, fl;
      @(negedge clk);
      en = ifc.pc_enable;
      fl = ifc.flush;
      @(posedge clk);
      #1;
      if (fl) ifc.pc_dir = target;
      else if (en) ifc.pc_dir = ifc.pc_dir + 32'd1;
      ifc.flush = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      ifc.flush = 1'b0;
      ifc.instr_ready = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_valid", 32'(ifc.instr_valid), 32'd0);
      check("rst_pc_enable", 32'(ifc.pc_enable), 32'd0);
      check("rst_mem_rd", 32'(ifc.mem_rd), 32'd0);
      check("rst_instr_out", ifc.instr_out, 32'd0);
      check("rst_instr_dir", ifc.instr_dir, 32'd0);
      check("rst_count", 32'(ifc.count), 32'd0);
      ifc.pc_dir = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
   endtask

   typedef struct {
      logic       ready;
      logic       en;
      logic [2:0] cnt;
      logic       valid;
   } vec_t;
   vec_t vecs[14];

   initial begin
      int pops0;
      // Backpressure from reset, ready released at cycle 8.
      vecs[0]  = '{1'b0, 1'b1, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 3'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 3'd0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 3'd1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 3'd2, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 3'd3, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 3'd4, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 3'd4, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 3'd4, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 3'd3, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 3'd2, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 3'd1, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 3'd1, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 3'd1, 1'b1};

      ifc.pc_dir = 32'd0;
      ifc.flush = 1'b0;
      ifc.instr_ready = 1'b0;
      target = 32'd0;

      // Streaming with ready held high.
      do_reset();
      for (int c = 0; c < 14; c++) begin
         ifc.instr_ready = 1'b1;
         #1;
         check("stream_pc_enable", 32'(ifc.pc_enable), 32'd1);
         check("stream_valid", 32'(ifc.instr_valid), 32'(c >= 3));
         if (c == 3) begin
            check("first_instr_out", ifc.instr_out, 32'h1000);
            check("first_instr_dir", ifc.instr_dir, 32'h0);
         end
         cyc();
      end

      // Table-driven backpressure.
      do_reset();
      for (int r = 0; r < 14; r++) begin
         ifc.instr_ready = vecs[r].ready;
         #1;
         check("vec_pc_enable", 32'(ifc.pc_enable), 32'(vecs[r].en));
         check("vec_count", 32'(ifc.count), 32'(vecs[r].cnt));
         check("vec_valid", 32'(ifc.instr_valid), 32'(vecs[r].valid));
         cyc();
      end

      // Flush with two buffered and two in flight.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         #1;
         cyc();
      end
      #1;
      check("fl_pre_count", 32'(ifc.count), 32'd2);
      target = 32'h100;
      ifc.flush = 1'b1;
      #1;
      check("fl_pc_enable", 32'(ifc.pc_enable), 32'd0);
      check("fl_mem_rd", 32'(ifc.mem_rd), 32'd0);
      cyc();
      ifc.instr_ready = 1'b1;
      #1;
      check("fl_post_count", 32'(ifc.count), 32'd0);
      check("fl_post_valid", 32'(ifc.instr_valid), 32'd0);
      check("fl_redirect_addr", ifc.mem_addr, 32'h100);
      for (int c = 5; c < 12; c++) begin
         #1;
         if (c < 8) check("fl_no_stale", 32'(ifc.instr_valid), 32'd0);
         if (c == 8) begin
            check("fl_new_dir", ifc.instr_dir, 32'h100);
            check("fl_new_instr", ifc.instr_out, 32'h1100);
         end
         cyc();
      end

      // Flush coincident with a memory return and a pop request.
      do_reset();
      ifc.instr_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         cyc();
      end
      #1;
      check("flr_pre_count", 32'(ifc.count), 32'd1);
      target = 32'h200;
      ifc.flush = 1'b1;
      #1;
      cyc();
      for (int c = 5; c < 10; c++) begin
         #1;
         if (c == 5) check("flr_post_count", 32'(ifc.count), 32'd0);
         if (c < 8) check("flr_valid", 32'(ifc.instr_valid), 32'd0);
         if (c == 8) check("flr_new_dir", ifc.instr_dir, 32'h200);
         cyc();
      end

      // Toggling ready.
      do_reset();
      pops0 = n_pop;
      for (int i = 0; i < 20; i++) begin
         ifc.instr_ready = i[0];
         #1;
         cyc();
      end
      ifc.instr_ready = 1'b1;
      repeat (6) begin
         #1;
         cyc();
      end
      check("toggle_progress", 32'(n_pop - pops0 >= 12), 32'd1);

      // Asynchronous reset mid-stream.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         #1;
         cyc();
      end
      #1;
      check("midrst_pre_count", 32'(ifc.count), 32'd3);
      #2;
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
